// File: rtl/unidade_pkg.sv
// Shared definitions for the sequencing control unit: opcodes, Ctrl bit indices,
// Mem2Reg encodings and FSM states.
package unidade_pkg;

    localparam logic [5:0] OP_ALU         = 6'h00;
    localparam logic [5:0] OP_LOGIC       = 6'h01;
    localparam logic [5:0] OP_ADDI        = 6'h02;
    localparam logic [5:0] OP_MOVE        = 6'h03;
    localparam logic [5:0] OP_SLT         = 6'h04;
    localparam logic [5:0] OP_J           = 6'h05;
    localparam logic [5:0] OP_LW          = 6'h06;
    localparam logic [5:0] OP_SW          = 6'h07;
    localparam logic [5:0] OP_IN          = 6'h08;
    localparam logic [5:0] OP_OUT         = 6'h09;
    localparam logic [5:0] OP_BEQ         = 6'h0A;
    localparam logic [5:0] OP_BNE         = 6'h0B;
    localparam logic [5:0] OP_NOP         = 6'h0C;
    localparam logic [5:0] OP_DIFF        = 6'h0D;
    localparam logic [5:0] OP_SBT         = 6'h0E;
    localparam logic [5:0] OP_EQUAL       = 6'h0F;
    localparam logic [5:0] OP_SBTE        = 6'h10;
    localparam logic [5:0] OP_SLTE        = 6'h11;
    localparam logic [5:0] OP_JR          = 6'h12;
    localparam logic [5:0] OP_SUBI        = 6'h13;
    localparam logic [5:0] OP_SET_PID     = 6'h14;
    localparam logic [5:0] OP_KERNEL_SWAP = 6'h15;
    localparam logic [5:0] OP_BEGIN_FILE  = 6'h16;
    localparam logic [5:0] OP_END_FILE    = 6'h17;
    localparam logic [5:0] OP_HD_HEAD     = 6'h18;
    localparam logic [5:0] OP_HALT        = 6'h19;
    localparam logic [5:0] OP_EMIT_MSG    = 6'h1A;
    localparam logic [5:0] OP_HD_END      = 6'h1B;
    localparam logic [5:0] OP_ROUND_ROBIN = 6'h1C;
    localparam logic [5:0] OP_CREATE_FILE = 6'h1D;
    localparam logic [5:0] OP_HD_WRITE    = 6'h1E;
    localparam logic [5:0] OP_HD_READ     = 6'h1F;
    localparam logic [5:0] OP_CLOSE_FILE  = 6'h20;

    localparam int CTRL_W        = 10;
    localparam int CTRL_OPIO     = 9;
    localparam int CTRL_MEMREAD  = 8;
    localparam int CTRL_MEMWRITE = 7;
    localparam int CTRL_REGWRITE = 6;
    localparam int CTRL_ALUSRC   = 5;
    localparam int CTRL_REGDST   = 4;
    localparam int CTRL_DESVIO   = 3;
    localparam int CTRL_TYPEJR   = 2;
    localparam int CTRL_WRITEHD  = 1;
    localparam int CTRL_PIDWR    = 0;

    localparam logic [1:0] M2R_MEM = 2'b00;
    localparam logic [1:0] M2R_IO  = 2'b01;
    localparam logic [1:0] M2R_ALU = 2'b10;
    localparam logic [1:0] M2R_HD  = 2'b11;

    typedef enum logic [1:0] {
        ST_EXEC    = 2'd0,
        ST_WAIT_IN = 2'd1,
        ST_WAIT_HD = 2'd2,
        ST_HALTED  = 2'd3
    } state_t;

    function automatic logic is_syscall(input logic [5:0] op);
        case (op)
            OP_BEGIN_FILE, OP_END_FILE, OP_HD_HEAD, OP_HD_END, OP_EMIT_MSG,
            OP_ROUND_ROBIN, OP_CREATE_FILE, OP_CLOSE_FILE, OP_KERNEL_SWAP: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/unidade_decode.sv
// Combinational opcode-to-Ctrl table. Syscall flagging only exists when
// UNIDADE_SYSCALL_EN is defined; otherwise syscall opcodes decode as NOP.
module unidade_decode
    import unidade_pkg::*;
#(
    parameter int OPCODE_W = 6
) (
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                valid,
    output logic [CTRL_W-1:0]   ctrl,
    output logic [1:0]          mem2reg,
    output logic                is_in,
    output logic                is_hd_write,
    output logic                is_hd_read,
    output logic                is_halt,
    output logic                is_sys
);

    logic [5:0] op6;
    logic       in_range;

    // Anything that does not fit in the 6-bit opcode space is treated as NOP.
    assign op6      = opcode[5:0];
    assign in_range = ((opcode >> 6) == '0);

    always_comb begin
        ctrl        = '0;
        mem2reg     = M2R_ALU;
        is_in       = 1'b0;
        is_hd_write = 1'b0;
        is_hd_read  = 1'b0;
        is_halt     = 1'b0;
        is_sys      = 1'b0;
        if (valid && in_range) begin
            case (op6)
                OP_ALU, OP_LOGIC, OP_MOVE, OP_SLT, OP_DIFF,
                OP_SBT, OP_EQUAL, OP_SBTE, OP_SLTE: begin
                    ctrl[CTRL_REGWRITE] = 1'b1;
                    ctrl[CTRL_REGDST]   = 1'b1;
                end
                OP_ADDI, OP_SUBI: begin
                    ctrl[CTRL_REGWRITE] = 1'b1;
                    ctrl[CTRL_ALUSRC]   = 1'b1;
                end
                OP_J, OP_BEQ, OP_BNE: ctrl[CTRL_DESVIO] = 1'b1;
                OP_LW: begin
                    ctrl[CTRL_MEMREAD]  = 1'b1;
                    ctrl[CTRL_REGWRITE] = 1'b1;
                    ctrl[CTRL_ALUSRC]   = 1'b1;
                    mem2reg             = M2R_MEM;
                end
                OP_SW: begin
                    ctrl[CTRL_MEMWRITE] = 1'b1;
                    ctrl[CTRL_ALUSRC]   = 1'b1;
                end
                OP_OUT:         ctrl[CTRL_OPIO] = 1'b1;
                OP_JR: begin
                    ctrl[CTRL_DESVIO] = 1'b1;
                    ctrl[CTRL_TYPEJR] = 1'b1;
                end
                OP_SET_PID:     ctrl[CTRL_PIDWR]    = 1'b1;
                OP_KERNEL_SWAP: ctrl[CTRL_REGWRITE] = 1'b1;
                OP_IN:          is_in       = 1'b1;
                OP_HD_WRITE:    is_hd_write = 1'b1;
                OP_HD_READ:     is_hd_read  = 1'b1;
                OP_HALT:        is_halt     = 1'b1;
                default: ;
            endcase
`ifdef UNIDADE_SYSCALL_EN
            is_sys = is_syscall(op6);
`endif
        end
    end

endmodule

// File: rtl/unidade_controle_seq.sv
// Multi-cycle sequencing control unit: single-cycle decode plus waits for IN,
// HD access (with timeout) and HALT. Syscall outputs depend on UNIDADE_SYSCALL_EN.
//
// state      | meaning
// ST_EXEC    | decode and issue; single-cycle opcodes complete here
// ST_WAIT_IN | IN issued, stalled until InAck, then write back input word
// ST_WAIT_HD | HD Write/Read pending, until HdDone or timeout
// ST_HALTED  | HALT executed, stalled until Resume
module unidade_controle_seq
    import unidade_pkg::*;
#(
    parameter int OPCODE_W   = 6,
    parameter int OPALU_W    = 6,
    parameter int HD_TIMEOUT = 255
) (
    input  logic                Clock,
    input  logic                Reset,
    input  logic [OPCODE_W-1:0] Opcode,
    input  logic                InstrValid,
    input  logic                InAck,
    input  logic                HdDone,
    input  logic                Resume,
    output logic [CTRL_W-1:0]   Ctrl,
    output logic [1:0]          Mem2Reg,
    output logic [OPALU_W-1:0]  OpALU,
    output logic                Stall,
    output logic                Halt,
    output logic                HdReq,
    output logic                HdTimeout,
    output logic                Syscall_Sign,
    output logic [OPCODE_W-1:0] SyscallCode
);

    localparam int CNT_W = (HD_TIMEOUT < 1) ? 1 : $clog2(HD_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(HD_TIMEOUT);

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  hd_write_q, hd_write_d;
    logic                  sys_sign_q;
    logic [OPCODE_W-1:0]   sys_code_q;

    logic [CTRL_W-1:0]     dec_ctrl;
    logic [1:0]            dec_m2r;
    logic                  dec_in, dec_hd_wr, dec_hd_rd, dec_halt, dec_sys;

    unidade_decode #(.OPCODE_W(OPCODE_W)) u_decode (
        .opcode      (Opcode),
        .valid       (InstrValid),
        .ctrl        (dec_ctrl),
        .mem2reg     (dec_m2r),
        .is_in       (dec_in),
        .is_hd_write (dec_hd_wr),
        .is_hd_read  (dec_hd_rd),
        .is_halt     (dec_halt),
        .is_sys      (dec_sys)
    );

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q    <= ST_EXEC;
            cnt_q      <= '0;
            hd_write_q <= 1'b0;
            sys_sign_q <= 1'b0;
            sys_code_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            hd_write_q <= hd_write_d;
            sys_sign_q <= (state_q == ST_EXEC) && dec_sys;
            if ((state_q == ST_EXEC) && dec_sys)
                sys_code_q <= Opcode;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        hd_write_d = hd_write_q;
        Ctrl       = '0;
        Mem2Reg    = M2R_ALU;
        OpALU      = '0;
        Stall      = 1'b0;
        Halt       = 1'b0;
        HdReq      = 1'b0;
        HdTimeout  = 1'b0;
        // Outputs follow the async reset immediately, even with InstrValid high.
        if (Reset) begin
            unique case (state_q)
                ST_EXEC: begin
                    Ctrl    = dec_ctrl;
                    Mem2Reg = dec_m2r;
                    if (dec_in) begin
                        Halt    = 1'b1;
                        Stall   = 1'b1;
                        state_d = ST_WAIT_IN;
                    end else if (dec_hd_wr || dec_hd_rd) begin
                        HdReq      = 1'b1;
                        Stall      = 1'b1;
                        cnt_d      = '0;
                        hd_write_d = dec_hd_wr;
                        state_d    = ST_WAIT_HD;
                    end else if (dec_halt) begin
                        Halt    = 1'b1;
                        Stall   = 1'b1;
                        state_d = ST_HALTED;
                    end
                end
                ST_WAIT_IN: begin
                    if (InAck) begin
                        Ctrl[CTRL_OPIO]     = 1'b1;
                        Ctrl[CTRL_REGWRITE] = 1'b1;
                        Mem2Reg             = M2R_IO;
                        state_d             = ST_EXEC;
                    end else begin
                        Halt  = 1'b1;
                        Stall = 1'b1;
                    end
                end
                ST_WAIT_HD: begin
                    HdReq = 1'b1;
                    // Completion wins over a timeout landing on the same cycle.
                    if (HdDone) begin
                        Ctrl[CTRL_REGWRITE] = 1'b1;
                        Ctrl[CTRL_WRITEHD]  = hd_write_q;
                        Ctrl[CTRL_MEMREAD]  = !hd_write_q;
                        Mem2Reg             = M2R_HD;
                        state_d             = ST_EXEC;
                    end else if (cnt_q == CNT_MAX) begin
                        HdTimeout = 1'b1;
                        state_d   = ST_EXEC;
                    end else begin
                        Stall = 1'b1;
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_HALTED: begin
                    Halt  = 1'b1;
                    Stall = 1'b1;
                    if (Resume)
                        state_d = ST_EXEC;
                end
            endcase
        end
    end

    assign Syscall_Sign = sys_sign_q;
    assign SyscallCode  = sys_code_q;

endmodule

// File: tb/tb_unidade_controle_seq.sv
// Scoreboard bench for unidade_controle_seq: directed scenarios plus random
// traffic, every cycle checked against a behavioural model.
module tb_unidade_controle_seq;

    localparam int OW = 7;
    localparam int AW = 6;
    localparam int TO = 4;

    localparam logic [9:0] B_OPIO = 10'h200;
    localparam logic [9:0] B_MEMR = 10'h100;
    localparam logic [9:0] B_MEMW = 10'h080;
    localparam logic [9:0] B_REGW = 10'h040;
    localparam logic [9:0] B_ALUS = 10'h020;
    localparam logic [9:0] B_REGD = 10'h010;
    localparam logic [9:0] B_DESV = 10'h008;
    localparam logic [9:0] B_TJR  = 10'h004;
    localparam logic [9:0] B_WHD  = 10'h002;
    localparam logic [9:0] B_PID  = 10'h001;

    logic          Clock = 1'b0;
    logic          Reset;
    logic [OW-1:0] Opcode;
    logic          InstrValid, InAck, HdDone, Resume;
    logic [9:0]    Ctrl;
    logic [1:0]    Mem2Reg;
    logic [AW-1:0] OpALU;
    logic          Stall, Halt, HdReq, HdTimeout, Syscall_Sign;
    logic [OW-1:0] SyscallCode;

    always #5 Clock = ~Clock;

    unidade_controle_seq #(.OPCODE_W(OW), .OPALU_W(AW), .HD_TIMEOUT(TO)) dut (
        .Clock(Clock), .Reset(Reset), .Opcode(Opcode), .InstrValid(InstrValid),
        .InAck(InAck), .HdDone(HdDone), .Resume(Resume), .Ctrl(Ctrl),
        .Mem2Reg(Mem2Reg), .OpALU(OpALU), .Stall(Stall), .Halt(Halt),
        .HdReq(HdReq), .HdTimeout(HdTimeout), .Syscall_Sign(Syscall_Sign),
        .SyscallCode(SyscallCode)
    );

    typedef struct packed {
        logic [9:0]    ctrl;
        logic [1:0]    m2r;
        logic [AW-1:0] alu;
        logic          stall, halt, hdreq, hdto, sys;
        logic [OW-1:0] code;
    } resp_t;

    resp_t exp_q[$];
    string phase_q[$];
    string phase = "init";
    int    checks = 0;
    int    errors = 0;

    // Reference model: what the unit is waiting for, in plain terms.
    bit            waiting_input, waiting_disk, halted, disk_is_write;
    int            disk_cycles;
    bit            sys_pulse;
    logic [OW-1:0] sys_code;

    function automatic bit is_sys_op(int op);
`ifdef UNIDADE_SYSCALL_EN
        return op inside {21, 22, 23, 24, 26, 27, 28, 29, 32};
`else
        return 1'b0;
`endif
    endfunction

    // Instruction semantics: {Ctrl, Mem2Reg} for single-cycle opcodes.
    function automatic logic [11:0] semantics(int op);
        case (op)
            0, 1, 3, 4, 13, 14, 15, 16, 17: return {B_REGW | B_REGD, 2'b10};
            2, 19:     return {B_REGW | B_ALUS, 2'b10};
            5, 10, 11: return {B_DESV, 2'b10};
            6:         return {B_MEMR | B_REGW | B_ALUS, 2'b00};
            7:         return {B_MEMW | B_ALUS, 2'b10};
            9:         return {B_OPIO, 2'b10};
            18:        return {B_DESV | B_TJR, 2'b10};
            20:        return {B_PID, 2'b10};
            21:        return {B_REGW, 2'b10};
            default:   return {10'h000, 2'b10};
        endcase
    endfunction

    function automatic resp_t expect_now();
        resp_t r;
        int    op;
        r       = '0;
        r.m2r   = 2'b10;
        r.sys   = sys_pulse;
        r.code  = sys_code;
        op      = int'(Opcode);
        if (!Reset) begin
            r.sys  = 1'b0;
            r.code = '0;
        end else if (waiting_input) begin
            if (InAck) begin
                r.ctrl = B_OPIO | B_REGW;
                r.m2r  = 2'b01;
            end else begin
                r.halt  = 1'b1;
                r.stall = 1'b1;
            end
        end else if (waiting_disk) begin
            r.hdreq = 1'b1;
            if (HdDone) begin
                r.ctrl = B_REGW | (disk_is_write ? B_WHD : B_MEMR);
                r.m2r  = 2'b11;
            end else if (disk_cycles == TO) begin
                r.hdto = 1'b1;
            end else begin
                r.stall = 1'b1;
            end
        end else if (halted) begin
            r.halt  = 1'b1;
            r.stall = 1'b1;
        end else if (InstrValid) begin
            {r.ctrl, r.m2r} = semantics(op);
            if (op == 8 || op == 25) begin
                r.halt  = 1'b1;
                r.stall = 1'b1;
            end else if (op == 30 || op == 31) begin
                r.hdreq = 1'b1;
                r.stall = 1'b1;
            end
        end
        return r;
    endfunction

    // Advance the model across a rising edge using the inputs of the cycle just ended.
    task automatic model_step();
        bit next_sys;
        int op;
        next_sys = 1'b0;
        op       = int'(Opcode);
        if (!Reset) begin
            waiting_input = 0; waiting_disk = 0; halted = 0; disk_is_write = 0;
            disk_cycles = 0;   sys_pulse = 0;   sys_code = '0;
            return;
        end
        if (waiting_input) begin
            if (InAck) waiting_input = 0;
        end else if (waiting_disk) begin
            if (HdDone || disk_cycles == TO) waiting_disk = 0;
            else disk_cycles++;
        end else if (halted) begin
            if (Resume) halted = 0;
        end else if (InstrValid) begin
            if (op == 8) waiting_input = 1;
            else if (op == 30 || op == 31) begin
                waiting_disk  = 1;
                disk_cycles   = 0;
                disk_is_write = (op == 30);
            end else if (op == 25) halted = 1;
            if (is_sys_op(op)) begin
                next_sys = 1'b1;
                sys_code = Opcode;
            end
        end
        sys_pulse = next_sys;
    endtask

    task automatic do_cycle(input logic rst, input logic valid, input int op,
                            input logic ack, input logic done, input logic res);
        @(posedge Clock);
        model_step();
        #1;
        Reset      = rst;
        InstrValid = valid;
        Opcode     = OW'(op);
        InAck      = ack;
        HdDone     = done;
        Resume     = res;
        exp_q.push_back(expect_now());
        phase_q.push_back(phase);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) do_cycle(1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    endtask

    // Monitor: the unit presents a full output word every cycle.
    initial begin
        resp_t e, a;
        string ph;
        forever begin
            @(negedge Clock);
            if (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                ph = phase_q.pop_front();
                a  = {Ctrl, Mem2Reg, OpALU, Stall, Halt, HdReq, HdTimeout, Syscall_Sign, SyscallCode};
                checks++;
                if (a !== e) begin
                    errors++;
                    $display("FAIL %s t=%0t got ctrl=%b m2r=%b alu=%h stall=%b halt=%b hdreq=%b hdto=%b sys=%b code=%h required ctrl=%b m2r=%b alu=%h stall=%b halt=%b hdreq=%b hdto=%b sys=%b code=%h",
                             ph, $time, a.ctrl, a.m2r, a.alu, a.stall, a.halt, a.hdreq, a.hdto, a.sys, a.code,
                             e.ctrl, e.m2r, e.alu, e.stall, e.halt, e.hdreq, e.hdto, e.sys, e.code);
                end
            end
        end
    end

    initial begin
        Reset = 1'b0; InstrValid = 1'b0; Opcode = '0; InAck = 1'b0; HdDone = 1'b0; Resume = 1'b0;
        waiting_input = 0; waiting_disk = 0; halted = 0; disk_is_write = 0;
        disk_cycles = 0; sys_pulse = 0; sys_code = '0;

        phase = "reset_state";
        do_cycle(1'b0, 1'b1, 2, 1'b0, 1'b0, 1'b0);
        do_cycle(1'b0, 1'b1, 31, 1'b1, 1'b1, 1'b1);

        phase = "addi";
        do_cycle(1'b1, 1'b1, 2, 1'b0, 1'b0, 1'b0);
        do_cycle(1'b1, 1'b1, 6, 1'b0, 1'b0, 1'b0);

        phase = "in_wait";
        do_cycle(1'b1, 1'b1, 8, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) do_cycle(1'b1, 1'b1, 2, 1'b0, 1'b0, 1'b0);
        do_cycle(1'b1, 1'b0, 0, 1'b1, 1'b0, 1'b0);
        idle(1);

        phase = "hd_read";
        do_cycle(1'b1, 1'b1, 31, 1'b0, 1'b0, 1'b0);
        idle(2);
        do_cycle(1'b1, 1'b0, 0, 1'b0, 1'b1, 1'b0);
        idle(1);

        phase = "hd_timeout";
        do_cycle(1'b1, 1'b1, 30, 1'b0, 1'b0, 1'b0);
        idle(7);

        phase = "hd_done_at_timeout";
        do_cycle(1'b1, 1'b1, 30, 1'b0, 1'b0, 1'b0);
        idle(4);
        do_cycle(1'b1, 1'b0, 0, 1'b0, 1'b1, 1'b0);
        idle(1);

        phase = "halt_reset";
        do_cycle(1'b1, 1'b1, 25, 1'b0, 1'b0, 1'b0);
        idle(2);
        do_cycle(1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b1);
        do_cycle(1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b1);
        do_cycle(1'b1, 1'b1, 2, 1'b0, 1'b0, 1'b1);

        phase = "halt_resume";
        do_cycle(1'b1, 1'b1, 25, 1'b0, 1'b0, 1'b0);
        idle(2);
        do_cycle(1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b1);
        idle(1);

        phase = "syscall_emit";
        do_cycle(1'b1, 1'b1, 26, 1'b0, 1'b0, 1'b0);
        idle(2);
        do_cycle(1'b1, 1'b1, 21, 1'b0, 1'b0, 1'b0);
        idle(1);

        phase = "wide_opcode_nop";
        do_cycle(1'b1, 1'b1, 64 + 2, 1'b0, 1'b0, 1'b0);
        do_cycle(1'b1, 1'b1, 64 + 8, 1'b0, 1'b0, 1'b0);
        idle(1);

        phase = "random";
        for (int i = 0; i < 3000; i++) begin
            int op;
            op = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 127))
                                             : int'($urandom_range(0, 33));
            do_cycle(($urandom_range(0, 99) != 0), ($urandom_range(0, 3) != 0), op,
                     ($urandom_range(0, 4) == 0), ($urandom_range(0, 6) == 0),
                     ($urandom_range(0, 4) == 0));
        end

        @(negedge Clock);
        #1;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain left=%0d required=0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/unidade_controle_seq.md
UNIDADE_CONTROLE_SEQ -- requirements
Module: unidade_controle_seq

Interface
REQ-001 Parameter OPCODE_W, default 6, opcode width; opcodes at or above 2^6 SHALL decode as NOP.
REQ-002 Parameter OPALU_W, default 6, OpALU width.
REQ-003 Parameter HD_TIMEOUT, default 255, max HD wait cycles; counter width SHALL be $clog2(HD_TIMEOUT+1).
REQ-004 Clock  in  1  sole clock, rising edge.
REQ-005 Reset  in  1  asynchronous, active-low reset.
REQ-006 Opcode  in  OPCODE_W  instruction opcode.
REQ-007 InstrValid  in  1  Opcode valid this cycle.
REQ-008 InAck  in  1  user input word available (IN completion).
REQ-009 HdDone  in  1  HD access complete.
REQ-010 Resume  in  1  leave HALTED.
REQ-011 Ctrl  out  10  {OpIO,MemRead,MemWrite,RegWrite,AluSrc,RegDst,Desvio,TypeJR,WriteHD,PID_wr}.
REQ-012 Mem2Reg  out  2  writeback select.
REQ-013 OpALU  out  OPALU_W  ALU op; all-zero for every opcode.
REQ-014 Stall  out  1  freeze PC/fetch.
REQ-015 Halt  out  1  waiting on IN or HALT.
REQ-016 HdReq  out  1  HD access request.
REQ-017 HdTimeout  out  1  one-cycle pulse, HD access abandoned.
REQ-018 Syscall_Sign  out  1  one-cycle syscall pulse.
REQ-019 SyscallCode  out  OPCODE_W  opcode of the current syscall.

Function
REQ-020 FSM states: EXEC, WAIT_IN, WAIT_HD, HALTED; transitions only on Clock rising edge.
REQ-021 EXEC with InstrValid=0: all Ctrl bits 0, Mem2Reg=2'b10, Stall=0.
REQ-022 EXEC with InstrValid=1: single-cycle opcodes (ALU, logic, ADDI, MOVE, SLT, J, LW, SW, OUT, BEQ, BNE, NOP, diff, sbt, equal, sbte, slte, JR, SUBI, SET_PID, KERNEL_SWAP) drive the decode table combinationally in the same cycle; no state change.
REQ-023 IN (0x08): Halt=1, Stall=1, RegWrite=0, next state WAIT_IN.
REQ-024 WAIT_IN: Halt=1, Stall=1 until InAck; the InAck cycle drives OpIO=1, RegWrite=1, Mem2Reg=01, Stall=0, then EXEC.
REQ-025 Write (0x1E) / Read (0x1F): HdReq=1, Stall=1, RegWrite=0, timeout counter cleared, next state WAIT_HD.
REQ-026 WAIT_HD: HdReq=1, Stall=1, counter increments each cycle; the HdDone cycle drives RegWrite=1, Mem2Reg=11, plus WriteHD=1 (Write) or MemRead=1 (Read), Stall=0, then EXEC.
REQ-027 WAIT_HD: when the counter reaches HD_TIMEOUT without HdDone, pulse HdTimeout, skip writeback, return to EXEC; HdDone on that same cycle has priority (normal completion).
REQ-028 HALT (0x19): Halt=1, Stall=1 in HALTED until Resume=1, then EXEC on the next edge; Resume outside HALTED is ignored.
REQ-029 Unknown opcodes: NOP, Stall=0.
REQ-030 InstrValid and Opcode are ignored outside EXEC.

Reset
REQ-031 While Reset=0: state EXEC, counter 0, Ctrl=0, Mem2Reg=10, OpALU=0, Stall=0, Halt=0, HdReq=0, HdTimeout=0, Syscall_Sign=0, SyscallCode=0.
REQ-032 Reset asserted mid-wait aborts the operation with no writeback; the first cycle after release is EXEC.

Configuration
REQ-033 Macro UNIDADE_SYSCALL_EN defined: BEGIN_FILE, END_FILE, HD_HEAD, HD_END, EMIT_MSG, ROUND_ROBIN, CREATE_FILE, CLOSE_FILE and KERNEL_SWAP with InstrValid=1 pulse Syscall_Sign=1 for one cycle and drive SyscallCode with the opcode (registered, held until the next syscall).
REQ-034 Macro undefined: Syscall_Sign and SyscallCode tied to 0; those opcodes behave as NOP (KERNEL_SWAP keeps its RegWrite decode).

Structure
REQ-035 Package unidade_pkg SHALL hold opcode localparams, the Ctrl bit-index constants, the Mem2Reg encodings and the FSM state enum.
REQ-036 The combinational opcode-to-Ctrl table SHALL be sub-module unidade_decode; the FSM overrides its outputs in wait states.

Verification
REQ-037 ADDI (0x02), InstrValid=1 -> same cycle RegWrite=1, AluSrc=1, Mem2Reg=10, Stall=0.
REQ-038 IN, InAck after 5 cycles -> Halt=Stall=1 for 6 cycles (IN issue cycle plus 5 wait cycles), then one cycle with RegWrite=1, Mem2Reg=01.
REQ-039 Read (0x1F), HdDone after 3 cycles -> HdReq=1 held, then one cycle with RegWrite=1, MemRead=1, Mem2Reg=11.
REQ-040 Write, HD_TIMEOUT=4, no HdDone -> HdTimeout pulse at count 4, no RegWrite/WriteHD, state EXEC.
REQ-041 HALT, then Reset low for 1 cycle during HALTED -> all outputs at reset values; Resume then has no effect.
REQ-042 With UNIDADE_SYSCALL_EN, EMIT_MSG (0x1A) -> Syscall_Sign pulse, SyscallCode=0x1A; without the macro, outputs remain 0.
